// File: rtl/led_breath_ctrl.sv
//------------------------------------------------------------------------------
// Module   : led_breath_ctrl
// Brief    : Breathing-envelope PWM sequencer for four LEDs (sync or chase).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_breath_ctrl #(
    parameter int TICK_DIV     = 50,
    parameter int PWM_STEPS    = 1000,
    parameter int DUTY_W       = 10,
    parameter int HOLD_PERIODS = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [DUTY_W-1:0] step,
    output logic [3:0]        pio_led,
    output logic              busy,
    output logic [DUTY_W-1:0] duty,
    output logic [1:0]        led_sel,
    output logic              done
);

    localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HCNT_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam int SUM_W  = DUTY_W + 1;

    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TICK_DIV - 1);
    localparam logic [DUTY_W-1:0] PCNT_MAX  = DUTY_W'(PWM_STEPS - 1);
    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PWM_STEPS);
    localparam logic [SUM_W-1:0]  SUM_FULL  = SUM_W'(PWM_STEPS);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(HOLD_PERIODS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP      = 3'd1,
        S_HOLD_HI = 3'd2,
        S_DOWN    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    state_t              state_q;
    logic [TCNT_W-1:0]   tcnt_q;
    logic [DUTY_W-1:0]   pcnt_q;
    logic [DUTY_W-1:0]   duty_q;
    logic [DUTY_W-1:0]   step_q;
    logic [HCNT_W-1:0]   hcnt_q;
    logic                mode_q;
    logic [1:0]          led_sel_q;
    logic [3:0]          pio_led_q;
    logic                done_q;

    logic                tick_w;
    logic                period_end_w;
    logic                pwm_w;
    logic [SUM_W-1:0]    sum_w;
    logic [3:0]          led_map_w;

    assign tick_w       = (state_q != S_IDLE) && (tcnt_q == TCNT_MAX);
    assign period_end_w = tick_w && (pcnt_q == PCNT_MAX);
    assign pwm_w        = (pcnt_q < duty_q);
    // Extra bit keeps duty+step from wrapping before the full-scale clamp.
    assign sum_w        = {1'b0, duty_q} + {1'b0, step_q};
    assign led_map_w    = mode_q ? ((4'b0001 << led_sel_q) & {4{pwm_w}}) : {4{pwm_w}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            pcnt_q    <= '0;
            duty_q    <= '0;
            step_q    <= '0;
            hcnt_q    <= '0;
            mode_q    <= 1'b0;
            led_sel_q <= 2'd0;
            pio_led_q <= 4'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                tcnt_q    <= '0;
                pcnt_q    <= '0;
                hcnt_q    <= '0;
                pio_led_q <= 4'd0;
                if (start && !stop) begin
                    state_q   <= S_UP;
                    mode_q    <= mode;
                    step_q    <= (step == '0) ? DUTY_W'(1) : step;
                    duty_q    <= '0;
                    led_sel_q <= 2'd0;
                end
            end else if (stop) begin
                state_q   <= S_IDLE;
                tcnt_q    <= '0;
                pcnt_q    <= '0;
                duty_q    <= '0;
                hcnt_q    <= '0;
                led_sel_q <= 2'd0;
                pio_led_q <= 4'd0;
            end else begin
                pio_led_q <= led_map_w;
                tcnt_q    <= tick_w ? '0 : tcnt_q + TCNT_W'(1);
                if (tick_w) begin
                    pcnt_q <= (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + DUTY_W'(1);
                end
                // Duty and state only move at period boundaries so every
                // PWM period is complete.
                if (period_end_w) begin
                    case (state_q)
                        S_UP: begin
                            if (sum_w >= SUM_FULL) begin
                                duty_q  <= DUTY_FULL;
                                hcnt_q  <= '0;
                                state_q <= S_HOLD_HI;
                            end else begin
                                duty_q <= sum_w[DUTY_W-1:0];
                            end
                        end
                        S_HOLD_HI: begin
                            if (hcnt_q == HCNT_MAX) begin
                                state_q <= S_DOWN;
                            end else begin
                                hcnt_q <= hcnt_q + HCNT_W'(1);
                            end
                        end
                        S_DOWN: begin
                            if (duty_q <= step_q) begin
                                duty_q  <= '0;
                                hcnt_q  <= '0;
                                state_q <= S_HOLD_LO;
                            end else begin
                                duty_q <= duty_q - step_q;
                            end
                        end
                        S_HOLD_LO: begin
                            if (hcnt_q == HCNT_MAX) begin
                                done_q  <= 1'b1;
                                state_q <= S_UP;
                                if (mode_q) begin
                                    led_sel_q <= led_sel_q + 2'd1;
                                end
                            end else begin
                                hcnt_q <= hcnt_q + HCNT_W'(1);
                            end
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign duty    = duty_q;
    assign led_sel = led_sel_q;
    assign pio_led = pio_led_q;
    assign done    = done_q;

endmodule

`default_nettype wire
